// File: rtl/axi_ic_pkg.sv
// Shared types and constants for the 4x4 AXI interconnect.
// Used by the per-slave read and write arbiters.
package axi_ic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } wr_arb_state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam int SEL_MSB = 31;
  localparam int SEL_LSB = 28;

endpackage

// File: rtl/axi_slave_wr_arbiter_rr_pick.sv
// Rotating-priority search: first set request at or after i_ptr.
// Shared with the read-channel arbiter.
module rr_pick #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_winner,
  output logic          o_found
);

  // Walk offsets from far to near so the nearest request wins.
  always_comb begin
    o_winner = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % N]) begin
        o_winner = '0;
        o_winner[(int'(i_ptr) + k) % N] = 1'b1;
      end
    end
  end

  assign o_found = |i_req;

endmodule

// File: rtl/axi_slave_wr_arbiter.sv
// Per-slave AXI4 write arbiter: round-robin grant held AW through B,
// one outstanding write per slave.
module axi_slave_wr_arbiter
  import axi_ic_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ID_W        = 4,
  parameter int SLAVE_IDX   = 0
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic [NUM_MASTERS-1:0]        m_awvalid,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_awaddr,
  input  logic [NUM_MASTERS*ID_W-1:0]   m_awid,
  output logic [NUM_MASTERS-1:0]        m_awready,
  input  logic [NUM_MASTERS-1:0]        m_wvalid,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [NUM_MASTERS-1:0]        m_wlast,
  output logic [NUM_MASTERS-1:0]        m_wready,
  output logic [NUM_MASTERS-1:0]        m_bvalid,
  output logic [ID_W-1:0]               m_bid,
  output logic [1:0]                    m_bresp,
  input  logic [NUM_MASTERS-1:0]        m_bready,
  output logic                          s_awvalid,
  output logic [ADDR_W-1:0]             s_awaddr,
  output logic [ID_W-1:0]               s_awid,
  input  logic                          s_awready,
  output logic                          s_wvalid,
  output logic [DATA_W-1:0]             s_wdata,
  output logic                          s_wlast,
  input  logic                          s_wready,
  input  logic                          s_bvalid,
  input  logic [ID_W-1:0]               s_bid,
  input  logic [1:0]                    s_bresp,
  output logic                          s_bready,
  output logic [NUM_MASTERS-1:0]        grant,
  output logic                          busy
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = SEL_MSB - SEL_LSB + 1;
  localparam logic [SW-1:0] SEL = SW'(SLAVE_IDX);
  localparam logic [PW-1:0] LAST = PW'(NUM_MASTERS - 1);

  logic [NUM_MASTERS-1:0] w_req;
  logic [NUM_MASTERS-1:0] w_win;
  logic                   w_found;
  logic [PW-1:0]          w_win_idx;

  wr_arb_state_e          r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [PW-1:0]          r_gidx;
  logic [PW-1:0]          r_ptr;
  logic                   r_busy;

  always_comb begin
    w_req = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_req[i] = m_awvalid[i] &&
        (m_awaddr[i*ADDR_W + SEL_LSB +: SW] == SEL);
    end
  end

  rr_pick #(
    .N (NUM_MASTERS)
  ) u_pick (
    .i_req    (w_req),
    .i_ptr    (r_ptr),
    .o_winner (w_win),
    .o_found  (w_found)
  );

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_win[i]) w_win_idx = PW'(i);
    end
  end

  // Payloads follow the latched owner; only valids/readies are gated.
  assign s_awaddr = m_awaddr[r_gidx*ADDR_W +: ADDR_W];
  assign s_awid   = m_awid[r_gidx*ID_W +: ID_W];
  assign s_wdata  = m_wdata[r_gidx*DATA_W +: DATA_W];
  assign s_wlast  = m_wlast[r_gidx];
  assign m_bid    = s_bid;
  assign m_bresp  = s_bresp;

  always_comb begin
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    unique case (r_state)
      ADDR: begin
        s_awvalid         = m_awvalid[r_gidx];
        m_awready[r_gidx] = s_awready;
      end
      DATA: begin
        s_wvalid         = m_wvalid[r_gidx];
        m_wready[r_gidx] = s_wready;
      end
      RESP: begin
        s_bready         = m_bready[r_gidx];
        m_bvalid[r_gidx] = s_bvalid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (w_found) begin
          r_state <= ADDR;
          r_grant <= w_win;
          r_gidx  <= w_win_idx;
          r_busy  <= 1'b1;
        end
        ADDR: if (s_awvalid && s_awready) r_state <= DATA;
        DATA: if (s_wvalid && s_wready && s_wlast) r_state <= RESP;
        RESP: if (s_bvalid && s_bready) begin
          r_state <= IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_ptr   <= (r_gidx == LAST) ? '0 : r_gidx + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant = r_grant;
  assign busy  = r_busy;

endmodule

// File: tb/tb_axi_slave_wr_arbiter.sv
// Randomized bench for axi_slave_wr_arbiter against a transaction-level
// model of the arbitration and routing rules, plus directed scenarios.
module tb_axi_slave_wr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  logic            ACLK = 1'b0;
  logic            ARESETn = 1'b0;
  logic [N-1:0]    m_awvalid = '0;
  logic [N*AW-1:0] m_awaddr = '0;
  logic [N*IW-1:0] m_awid = '0;
  logic [N-1:0]    m_awready;
  logic [N-1:0]    m_wvalid = '0;
  logic [N*DW-1:0] m_wdata = '0;
  logic [N-1:0]    m_wlast = '0;
  logic [N-1:0]    m_wready;
  logic [N-1:0]    m_bvalid;
  logic [IW-1:0]   m_bid;
  logic [1:0]      m_bresp;
  logic [N-1:0]    m_bready = '0;
  logic            s_awvalid;
  logic [AW-1:0]   s_awaddr;
  logic [IW-1:0]   s_awid;
  logic            s_awready = 1'b0;
  logic            s_wvalid;
  logic [DW-1:0]   s_wdata;
  logic            s_wlast;
  logic            s_wready = 1'b0;
  logic            s_bvalid = 1'b0;
  logic [IW-1:0]   s_bid = '0;
  logic [1:0]      s_bresp = '0;
  logic            s_bready;
  logic [N-1:0]    grant;
  logic            busy;

  axi_slave_wr_arbiter dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .m_awvalid (m_awvalid),
    .m_awaddr  (m_awaddr),
    .m_awid    (m_awid),
    .m_awready (m_awready),
    .m_wvalid  (m_wvalid),
    .m_wdata   (m_wdata),
    .m_wlast   (m_wlast),
    .m_wready  (m_wready),
    .m_bvalid  (m_bvalid),
    .m_bid     (m_bid),
    .m_bresp   (m_bresp),
    .m_bready  (m_bready),
    .s_awvalid (s_awvalid),
    .s_awaddr  (s_awaddr),
    .s_awid    (s_awid),
    .s_awready (s_awready),
    .s_wvalid  (s_wvalid),
    .s_wdata   (s_wdata),
    .s_wlast   (s_wlast),
    .s_wready  (s_wready),
    .s_bvalid  (s_bvalid),
    .s_bid     (s_bid),
    .s_bresp   (s_bresp),
    .s_bready  (s_bready),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 ACLK = ~ACLK;

  // Model: phase 0 idle, 1 address, 2 data, 3 response.
  int ph = 0;
  int own = -1;
  int mptr = 0;
  int pend [N];
  int life [N];
  int len [N];
  int beat [N];
  logic [AW-1:0] addr [N];
  logic [IW-1:0] id [N];
  logic [DW-1:0] data [N][8];

  bit rnd = 0;
  bit gen_en = 0;
  bit wtog = 0;
  bit tgl = 1;
  int vectors = 0;
  int errs = 0;
  int dlog [$];
  logic [N-1:0] prev_g = '0;
  int hs = 0;
  int lasts = 0;
  int last_at = 0;
  int early = 0;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    vectors++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic bit is_mine(int m);
    return addr[m][31:28] == 4'd0;
  endfunction

  function automatic bit any_pend();
    bit r;
    r = 0;
    for (int i = 0; i < N; i++) if (pend[i] != 0) r = 1;
    return r;
  endfunction

  task automatic new_txn(input int m, input logic [AW-1:0] a,
                         input int l, input logic [IW-1:0] i_id);
    pend[m] = 1;
    addr[m] = a;
    id[m]   = i_id;
    len[m]  = l;
    beat[m] = 0;
    life[m] = $urandom_range(5, 20);
    for (int k = 0; k < 8; k++) data[m][k] = $urandom;
  endtask

  task automatic set_txn(input int m, input logic [AW-1:0] a,
                         input int l, input logic [DW-1:0] d);
    new_txn(m, a, l, IW'(m));
    for (int k = 0; k < 8; k++) data[m][k] = d + DW'(k);
  endtask

  task automatic drive();
    logic [3:0] nib;
    for (int i = 0; i < N; i++) begin
      if (gen_en && pend[i] == 0 && (!rnd || $urandom % 4 == 0)) begin
        nib = 4'd0;
        if (rnd && $urandom % 6 == 0) nib = 4'($urandom_range(1, 15));
        new_txn(i, {nib, 28'($urandom)},
                rnd ? $urandom_range(1, 4) : 1, IW'($urandom));
      end
      m_awvalid[i] = pend[i] == 1;
      m_awaddr[i*AW +: AW] = addr[i];
      m_awid[i*IW +: IW] = id[i];
      m_wvalid[i] = rnd ? ($urandom % 4 != 0) : 1'b1;
      m_wdata[i*DW +: DW] = data[i][beat[i]];
      m_wlast[i] = beat[i] == len[i] - 1;
      m_bready[i] = rnd ? 1'($urandom) : 1'b1;
    end
    s_awready = rnd ? 1'($urandom) : 1'b1;
    s_bvalid  = rnd ? 1'($urandom) : 1'b1;
    s_bid     = rnd ? IW'($urandom) : ((own >= 0) ? id[own] : '0);
    s_bresp   = rnd ? 2'($urandom) : 2'b00;
    if (wtog && ph == 2) begin
      s_wready = tgl;
      tgl = !tgl;
    end else begin
      s_wready = rnd ? 1'($urandom) : 1'b1;
      tgl = 1;
    end
  endtask

  task automatic check();
    logic [N-1:0] eg, ea, ew, eb;
    logic eav, ewv, ebr;
    eg = '0; ea = '0; ew = '0; eb = '0;
    eav = 0; ewv = 0; ebr = 0;
    if (ph != 0) begin
      eg[own] = 1'b1;
      case (ph)
        1: begin ea[own] = s_awready; eav = m_awvalid[own]; end
        2: begin ew[own] = s_wready; ewv = m_wvalid[own]; end
        default: begin eb[own] = s_bvalid; ebr = m_bready[own]; end
      endcase
    end
    chk("grant", grant, eg);
    chk("busy", busy, ph != 0);
    chk("m_awready", m_awready, ea);
    chk("m_wready", m_wready, ew);
    chk("m_bvalid", m_bvalid, eb);
    chk("s_awvalid", s_awvalid, eav);
    chk("s_wvalid", s_wvalid, ewv);
    chk("s_bready", s_bready, ebr);
    if (ph == 1) begin
      chk("s_awaddr", s_awaddr, addr[own]);
      chk("s_awid", s_awid, id[own]);
    end
    if (ph == 2) begin
      chk("s_wdata", s_wdata, data[own][beat[own]]);
      chk("s_wlast", s_wlast, beat[own] == len[own] - 1);
    end
    if (ph == 3) begin
      chk("m_bid", m_bid, s_bid);
      chk("m_bresp", m_bresp, s_bresp);
    end
  endtask

  task automatic observe();
    if (grant != 0 && prev_g == 0) begin
      for (int i = 0; i < N; i++) if (grant[i]) dlog.push_back(i);
    end
    prev_g = grant;
    if (m_bvalid != 0 && hs < 4) early++;
    if (s_wvalid && s_wready) begin
      hs++;
      if (s_wlast) begin lasts++; last_at = hs; end
    end
  endtask

  task automatic step();
    bit found;
    found = 0;
    case (ph)
      0: for (int k = 0; k < N; k++) begin
        if (!found && pend[(mptr + k) % N] == 1
            && is_mine((mptr + k) % N)) begin
          found = 1;
          own = (mptr + k) % N;
          ph = 1;
        end
      end
      1: if (pend[own] == 1 && s_awready) begin
        ph = 2;
        pend[own] = 2;
      end
      2: if (m_wvalid[own] && s_wready) begin
        if (beat[own] == len[own] - 1) ph = 3;
        else beat[own]++;
      end
      default: if (s_bvalid && m_bready[own]) begin
        ph = 0;
        pend[own] = 0;
        mptr = (own + 1) % N;
        own = -1;
      end
    endcase
    for (int i = 0; i < N; i++) begin
      if (pend[i] == 1 && !is_mine(i)) begin
        life[i]--;
        if (life[i] <= 0) pend[i] = 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge ACLK); #1;
    drive();
    @(negedge ACLK);
    check();
    observe();
    step();
  endtask

  task automatic assert_reset();
    ARESETn = 1'b1;
    #1;
    chk("rst_grant", grant, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_s_awvalid", s_awvalid, 1'b0);
    chk("rst_s_wvalid", s_wvalid, 1'b0);
    chk("rst_s_bready", s_bready, 1'b0);
    chk("rst_m_awready", m_awready, 4'b0000);
    chk("rst_m_wready", m_wready, 4'b0000);
    chk("rst_m_bvalid", m_bvalid, 4'b0000);
    ph = 0; own = -1; mptr = 0; prev_g = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; beat[i] = 0; len[i] = 1; addr[i] = '0; id[i] = '0;
    end
    m_awvalid = '0; m_wvalid = '0; m_bready = '0; m_wlast = '0;
    s_awready = 0; s_wready = 0; s_bvalid = 0;
    @(posedge ACLK); #1;
    ARESETn = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge ACLK); #1;
    assert_reset();
  endtask

  task automatic run_until_idle(input int maxc);
    int c;
    c = 0;
    do begin
      cycle();
      c++;
    end while ((ph != 0 || any_pend()) && c < maxc);
    chk("drain_timeout", (ph != 0 || any_pend()), 1'b0);
  endtask

  initial begin
    int c;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; beat[i] = 0; len[i] = 1; addr[i] = '0; id[i] = '0;
      life[i] = 0;
      for (int k = 0; k < 8; k++) data[i][k] = '0;
    end

    // Single request from master 2.
    do_reset();
    set_txn(2, 32'h0000_0010, 1, 32'hCCCC_2222);
    cycle();
    chk("single_pre_grant", grant, 4'b0000);
    cycle();
    chk("single_grant", grant, 4'b0100);
    chk("single_awvalid", s_awvalid, 1'b1);
    chk("single_awaddr", s_awaddr, 32'h0000_0010);
    cycle();
    chk("single_wdata", s_wdata, 32'hCCCC_2222);
    chk("single_wlast", s_wlast, 1'b1);
    cycle();
    chk("single_bvalid", m_bvalid, 4'b0100);
    chk("single_bid", m_bid, 4'd2);
    chk("single_bresp", m_bresp, 2'b00);
    cycle();
    chk("single_busy_drop", busy, 1'b0);
    chk("single_ptr", mptr, 3);

    // Contention between masters 0 and 1.
    do_reset();
    dlog.delete();
    set_txn(0, 32'h0000_0100, 1, 32'h1000);
    set_txn(1, 32'h0000_0200, 1, 32'h2000);
    run_until_idle(40);
    chk("cont_count", dlog.size(), 2);
    if (dlog.size() == 2) begin
      chk("cont_first", dlog[0], 0);
      chk("cont_second", dlog[1], 1);
    end
    chk("cont_ptr", mptr, 2);

    // Fairness with all masters requesting continuously.
    do_reset();
    dlog.delete();
    gen_en = 1;
    c = 0;
    while (dlog.size() < 8 && c < 100) begin cycle(); c++; end
    gen_en = 0;
    run_until_idle(40);
    chk("fair_count_min", dlog.size() >= 8, 1'b1);
    for (int k = 0; k < 8 && k < dlog.size(); k++)
      chk("fair_order", dlog[k], k % 4);

    // Decode filter: master 3 targets another slave.
    do_reset();
    set_txn(3, 32'h3000_0000, 1, 32'h3333);
    life[3] = 100;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("decode_grant", grant, 4'b0000);
      chk("decode_awready3", m_awready[3], 1'b0);
    end

    // Four-beat burst with WREADY toggling.
    do_reset();
    wtog = 1;
    hs = 0; lasts = 0; last_at = 0; early = 0;
    set_txn(0, 32'h0000_0040, 4, 32'hA0);
    run_until_idle(40);
    wtog = 0;
    chk("burst_handshakes", hs, 4);
    chk("burst_wlast_count", lasts, 1);
    chk("burst_wlast_beat", last_at, 4);
    chk("burst_early_resp", early, 0);

    // Reset during DATA, then arbitration restarts from pointer 0.
    do_reset();
    set_txn(2, 32'h0000_0020, 1, 32'h5);
    run_until_idle(20);
    chk("rst_pre_ptr", mptr, 3);
    set_txn(3, 32'h0000_0030, 4, 32'h77);
    c = 0;
    while (ph != 2 && c < 20) begin cycle(); c++; end
    @(posedge ACLK); #1;
    chk("rst_mid_in_data", s_wvalid, 1'b1);
    assert_reset();
    set_txn(1, 32'h0000_0011, 1, 32'h11);
    set_txn(3, 32'h0000_0033, 1, 32'h33);
    cycle();
    cycle();
    chk("rst_post_grant", grant, 4'b0010);
    run_until_idle(40);

    // Randomized traffic with a mid-stream reset.
    do_reset();
    rnd = 1;
    gen_en = 1;
    repeat (1500) cycle();
    do_reset();
    repeat (1500) cycle();
    gen_en = 0;
    run_until_idle(300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/axi_slave_wr_arbiter.md
# axi_slave_wr_arbiter

Per-slave AXI4 write-channel arbiter for the 4x4 AXI interconnect. It sits in front of one slave port and decodes which masters address that slave. It grants one master at a time in round-robin order and routes the AW, W and B channels between that master and the slave. The grant is held from the AW handshake through the B handshake, so there is one outstanding write per slave.

## Interface
Parameters:
- NUM_MASTERS, 4, number of requesting masters
- ADDR_W, 32, address width
- DATA_W, 32, data width
- ID_W, 4, AXI ID width
- SLAVE_IDX, 0, value of ADDR[31:28] that selects this slave

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  reset; asynchronous, active-high (despite the name)
- m_awvalid  in  NUM_MASTERS  per-master AWVALID
- m_awaddr  in  NUM_MASTERS*ADDR_W  per-master AWADDR, master i at slice i
- m_awid  in  NUM_MASTERS*ID_W  per-master AWID
- m_awready  out  NUM_MASTERS  per-master AWREADY
- m_wvalid  in  NUM_MASTERS  per-master WVALID
- m_wdata  in  NUM_MASTERS*DATA_W  per-master WDATA
- m_wlast  in  NUM_MASTERS  per-master WLAST
- m_wready  out  NUM_MASTERS  per-master WREADY
- m_bvalid  out  NUM_MASTERS  per-master BVALID
- m_bid  out  ID_W  BID, shared across masters
- m_bresp  out  2  BRESP, shared across masters
- m_bready  in  NUM_MASTERS  per-master BREADY
- s_awvalid / s_awaddr / s_awid  out  1 / ADDR_W / ID_W  slave AW channel
- s_awready  in  1  slave AWREADY
- s_wvalid / s_wdata / s_wlast  out  1 / DATA_W / 1  slave W channel
- s_wready  in  1  slave WREADY
- s_bvalid / s_bid / s_bresp  in  1 / ID_W / 2  slave B channel
- s_bready  out  1  slave BREADY
- grant  out  NUM_MASTERS  one-hot current owner; all zero in IDLE
- busy  out  1  high whenever state is not IDLE

## Operation
Request and pointer:
- req[i] = m_awvalid[i] && m_awaddr[i][31:28] == SLAVE_IDX.
- Round-robin pointer ptr is reset to 0.
- Search order is ptr, ptr+1, …, NUM_MASTERS-1, 0, …, ptr-1. The first set req[i] wins.

FSM states are IDLE, ADDR, DATA, RESP.
- IDLE: if any req is set, register grant = winner and go to ADDR.
- ADDR: s_aw* = granted master's aw*, and m_awready[g] = s_awready. On AW handshake (s_awvalid && s_awready), go to DATA.
- DATA: s_w* = granted master's w*, and m_wready[g] = s_wready. On a W handshake with s_wlast = 1, go to RESP.
- RESP: m_bvalid[g] = s_bvalid, m_bid = s_bid, m_bresp = s_bresp, s_bready = m_bready[g]. On B handshake, go to IDLE, clear grant, and set ptr = (g+1) mod NUM_MASTERS.

Routing rules:
- Ungranted masters always see awready, wready and bvalid at 0.
- All slave-side valids are 0 outside their state.
- The B channel passes s_bid through unchanged. Routing uses the latched grant, not BID.
- Simultaneous requests: the pointer order decides. Losing masters keep AWVALID asserted and wait.
- A master whose address decodes to another slave is never granted here.
- Multi-beat bursts: W stays in DATA until the WLAST beat. No beat is dropped or duplicated.

Reset:
- Reset asserted at any time, including mid-burst, forces state IDLE, ptr 0, grant 0, busy 0.
- All slave-side and master-side valid/ready outputs are 0 while reset is asserted.
- The transaction in flight is abandoned.

## Timing
- Request to grant: 1 cycle, registered. A req sampled at edge n gives grant and s_awvalid high after edge n.
- AW, W and B routing is combinational through the granted mux. There is no added latency per beat.
- Single-beat write with an always-ready slave and a 1-cycle B response: AW at edge n+1, W at edge n+2, B at edge n+3 or later. The next grant follows one cycle after the B handshake.
- Back-to-back grants: IDLE always lasts exactly one cycle when a req is pending.
- Widths: ptr and the grant index are $clog2(NUM_MASTERS) bits. Wrap-around from NUM_MASTERS-1 to 0 is required.

## Structure
- Shared package axi_ic_pkg holds:
  - the wr_arb_state_e enum (IDLE/ADDR/DATA/RESP)
  - BRESP constants OKAY/EXOKAY/SLVERR/DECERR
  - decode constants SEL_MSB=31 and SEL_LSB=28
- Sub-module rr_pick is a combinational rotating-priority search. Inputs are req and ptr; outputs are a one-hot winner and a found flag. The same block is reused by the read-channel arbiter.

## Test plan
- Single request: master 2 writes addr 0x0000_0010, data 0xCCCC_2222, into SLAVE_IDX 0.
  - grant = 0100 one cycle later.
  - s_awaddr = 0x0000_0010, s_wdata = 0xCCCC_2222.
  - m_bvalid[2] pulses with bid = 2 and bresp = 00.
  - busy drops after the B handshake.
- Contention: masters 0 and 1 request 0x0000_0100 and 0x0000_0200 in the same cycle, with ptr = 0.
  - Master 0 completes first, then master 1.
  - ptr ends at 2.
- Fairness: all 4 masters request continuously for 8 transactions.
  - Grant order is 0,1,2,3,0,1,2,3.
- Decode filter: master 3 requests addr 0x3000_0000 while SLAVE_IDX = 0.
  - No grant; m_awready[3] stays 0.
- Burst with backpressure: a 4-beat burst with s_wready toggling 1,0,1,0.
  - Exactly 4 W handshakes occur, with WLAST on the 4th.
  - RESP is entered only after that beat.
- Reset mid-burst: assert ARESETn during DATA.
  - In the same cycle, state returns to IDLE, grant becomes 0 and all valids become 0.
  - After release, a new request is granted starting from ptr 0.
